// File: rtl/pipe_ctrl_pkg.sv
// Shared control-bundle bit positions, forwarding encodings and zero bundles
// for the pipeline control/hazard block.
package pipe_ctrl_pkg;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 0;
  localparam int MEM_BRANCH  = 2;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [3:0] ZERO_EX  = 4'b0000;
  localparam logic [2:0] ZERO_MEM = 3'b000;
  localparam logic [1:0] ZERO_WB  = 2'b00;

  // Winning hazard action for the current cycle, highest priority last.
  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_JUMP   = 2'd1,
    ACT_STALL  = 2'd2,
    ACT_BRANCH = 2'd3
  } hazard_act_e;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// Forwarding comparator for one EX-stage ALU operand; the EX/MEM producer
// takes precedence over MEM/WB, and register 0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] exmem_dst,
  input  logic             memwb_regwrite,
  input  logic [REG_W-1:0] memwb_dst,
  input  logic [REG_W-1:0] src,
  output logic [1:0]       sel
);

  always_comb begin
    sel = FWD_RF;
    if (FWD_EN) begin
      if (exmem_regwrite && (exmem_dst != '0) && (exmem_dst == src))
        sel = FWD_EXMEM;
      else if (memwb_regwrite && (memwb_dst != '0) && (memwb_dst == src))
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control half of a 5-stage MIPS pipeline: carries decoder control through
// ID/EX, EX/MEM and MEM/WB, resolves load-use/branch/jump hazards, drives forwarding.
module ctrl_pipe_hazard
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_jump,
  input  logic             id_if_flush,
  input  logic [3:0]       id_ex,
  input  logic [2:0]       id_mem,
  input  logic [1:0]       id_wb,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic [3:0]       ex_ctrl,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [2:0]       mem_ctrl,
  output logic [1:0]       mem_wb_ctrl,
  output logic [REG_W-1:0] mem_dst,
  output logic [1:0]       wb_ctrl,
  output logic [REG_W-1:0] wb_dst,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             if_flush,
  output logic             pc_src,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  logic [3:0]       ex_ctrl_reg;
  logic [2:0]       ex_memc_reg;
  logic [1:0]       ex_wbc_reg;
  logic [REG_W-1:0] ex_rs_reg, ex_rt_reg, ex_rd_reg;
  logic [2:0]       mem_ctrl_reg;
  logic [1:0]       mem_wbc_reg;
  logic [REG_W-1:0] mem_dst_reg;
  logic [1:0]       wb_ctrl_reg;
  logic [REG_W-1:0] wb_dst_reg;

  logic             branch_taken, load_use;
  logic             idex_bubble, exmem_bubble;
  logic [REG_W-1:0] ex_dst;
  hazard_act_e      act;

  always_comb begin
    ex_dst       = ex_ctrl_reg[EX_REGDST] ? ex_rd_reg : ex_rt_reg;
    branch_taken = mem_ctrl_reg[MEM_BRANCH] & mem_zero;
    load_use     = ex_memc_reg[MEM_READ] & (ex_rt_reg != '0) &
                   ((ex_rt_reg == id_rs) | (ex_rt_reg == id_rt));

    if (branch_taken)  act = ACT_BRANCH;
    else if (load_use) act = ACT_STALL;
    else if (id_jump)  act = ACT_JUMP;
    else               act = ACT_NONE;

    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    if_flush     = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    unique case (act)
      ACT_BRANCH: begin
        if_flush     = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
      end
      ACT_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      ACT_JUMP: begin
        if_flush    = id_if_flush;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // Bubbles hold the ID/EX tags so a jump's undefined decoder fields never load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_reg  <= ZERO_EX;
      ex_memc_reg  <= ZERO_MEM;
      ex_wbc_reg   <= ZERO_WB;
      ex_rs_reg    <= '0;
      ex_rt_reg    <= '0;
      ex_rd_reg    <= '0;
      mem_ctrl_reg <= ZERO_MEM;
      mem_wbc_reg  <= ZERO_WB;
      mem_dst_reg  <= '0;
      wb_ctrl_reg  <= ZERO_WB;
      wb_dst_reg   <= '0;
    end else begin
      if (idex_bubble) begin
        ex_ctrl_reg <= ZERO_EX;
        ex_memc_reg <= ZERO_MEM;
        ex_wbc_reg  <= ZERO_WB;
      end else begin
        ex_ctrl_reg <= id_ex;
        ex_memc_reg <= id_mem;
        ex_wbc_reg  <= id_wb;
        ex_rs_reg   <= id_rs;
        ex_rt_reg   <= id_rt;
        ex_rd_reg   <= id_rd;
      end
      mem_ctrl_reg <= exmem_bubble ? ZERO_MEM : ex_memc_reg;
      mem_wbc_reg  <= exmem_bubble ? ZERO_WB : ex_wbc_reg;
      mem_dst_reg  <= ex_dst;
      wb_ctrl_reg  <= mem_wbc_reg;
      wb_dst_reg   <= mem_dst_reg;
    end
  end

  logic [REG_W-1:0] fwd_src [2];
  logic [1:0]       fwd_sel [2];

  assign fwd_src[0] = ex_rs_reg;
  assign fwd_src[1] = ex_rt_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_unit #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd (
        .exmem_regwrite (mem_wbc_reg[WB_REGWRITE]),
        .exmem_dst      (mem_dst_reg),
        .memwb_regwrite (wb_ctrl_reg[WB_REGWRITE]),
        .memwb_dst      (wb_dst_reg),
        .src            (fwd_src[gi]),
        .sel            (fwd_sel[gi])
      );
    end
  endgenerate

  assign fwd_a       = fwd_sel[0];
  assign fwd_b       = fwd_sel[1];
  assign pc_src      = branch_taken;
  assign ex_ctrl     = ex_ctrl_reg;
  assign ex_rs       = ex_rs_reg;
  assign ex_rt       = ex_rt_reg;
  assign mem_ctrl    = mem_ctrl_reg;
  assign mem_wb_ctrl = mem_wbc_reg;
  assign mem_dst     = mem_dst_reg;
  assign wb_ctrl     = wb_ctrl_reg;
  assign wb_dst      = wb_dst_reg;

endmodule
